hit_map_reader: RTL

HIT_MAP_READER -- requirements
Module: hit_map_reader

---
 rtl/hit_map_reader.sv | 118 +++++++++++
 1 files changed

// File: rtl/hit_map_reader.sv
// Drains a 1-bit-wide result memory from address 0 up to last-1 and packs the bits LSB-first into bytes.
// Latency: 2 cycles per bit (READ + WAIT), then at least one EMIT cycle per byte; done pulses one cycle after DONE.
// Backpressure: EMIT holds out_byte/out_bits/out_valid stable and issues no reads until out_ready is seen.
module hit_map_reader (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [11:0] last,
  output logic [11:0] mem_addr,
  output logic        mem_rd,
  input  logic        mem_data,
  output logic [7:0]  out_byte,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_bits,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_EMIT,
    S_DONE
  } state_t;

  state_t      state;
  logic [11:0] addr;
  logic [11:0] end_r;
  logic [7:0]  pack;
  logic [7:0]  pack_nxt;
  logic [11:0] addr_inc;

  // Merge the returning memory bit into its LSB-first slot and precompute the next address.
  always_comb begin
    pack_nxt = pack | ({7'd0, mem_data} << addr[2:0]);
    addr_inc = addr + 12'd1;
  end

  // Drain FSM; every output is registered and set on the transition into the state that owns it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      addr      <= 12'd0;
      end_r     <= 12'd0;
      pack      <= 8'd0;
      mem_addr  <= 12'd0;
      mem_rd    <= 1'b0;
      out_byte  <= 8'd0;
      out_valid <= 1'b0;
      out_bits  <= 4'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      mem_rd <= 1'b0;
      // done trails the DONE state by one cycle so it is visible as a clean single pulse
      done   <= (state == S_DONE);
      case (state)
        S_IDLE: begin
          if (start) begin
            end_r <= last;
            addr  <= 12'd0;
            pack  <= 8'd0;
            if (last == 12'd0) begin
              state <= S_DONE;
            end else begin
              state    <= S_READ;
              mem_rd   <= 1'b1;
              mem_addr <= 12'd0;
              busy     <= 1'b1;
            end
          end
        end
        S_READ: begin
          // mem_rd was raised on entry; the bit returns during WAIT
          state <= S_WAIT;
        end
        S_WAIT: begin
          pack <= pack_nxt;
          addr <= addr_inc;
          if ((addr[2:0] == 3'd7) || (addr_inc == end_r)) begin
            state     <= S_EMIT;
            out_valid <= 1'b1;
            out_byte  <= pack_nxt;
            out_bits  <= {1'b0, addr[2:0]} + 4'd1;
          end else begin
            state    <= S_READ;
            mem_rd   <= 1'b1;
            mem_addr <= addr_inc;
          end
        end
        S_EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            pack      <= 8'd0;
            if (addr != end_r) begin
              state    <= S_READ;
              mem_rd   <= 1'b1;
              mem_addr <= addr;
            end else begin
              state <= S_DONE;
              busy  <= 1'b0;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
